// File: rtl/adder_share_arbiter_if.sv
// Request/operand/response bundle between the requesting clients (plus the
// shared adder) and adder_share_arbiter.
interface adder_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned W       = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*W-1:0] op_a;
  logic [NUM_REQ*W-1:0] op_b;
  logic [W-1:0]         add_a;
  logic [W-1:0]         add_b;
  logic [W:0]           add_sum;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [W:0]           resp_sum;
  logic                 busy;

  modport master (
    output req, op_a, op_b, add_sum,
    input  add_a, add_b, grant, resp_valid, resp_sum, busy
  );

  modport slave (
    input  req, op_a, op_b, add_sum,
    output add_a, add_b, grant, resp_valid, resp_sum, busy
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one W-bit adder between NUM_REQ
// requesters and returns each captured sum with a one-cycle strobe.
module adder_share_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned W         = 4,
  parameter int unsigned ADDER_LAT = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  adder_share_arbiter_if.slave bus
);
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(ADDER_LAT + 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      k;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [W-1:0]       add_a_q;
  logic [W-1:0]       add_b_q;
  logic [W:0]         resp_sum_q;

  logic               found_hi;
  logic [PW-1:0]      win_hi;
  logic [PW-1:0]      win_lo;
  logic [PW-1:0]      win;
  logic [NUM_REQ-1:0] win_oh;
  logic [W-1:0]       sel_a;
  logic [W-1:0]       sel_b;

  // Rotating search from ptr: the lowest request at or above ptr wins,
  // otherwise the lowest request overall (the wrap-around case).
  always_comb begin
    found_hi = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (bus.req[NUM_REQ-1-i]) begin
        win_lo = PW'(NUM_REQ-1-i);
        if ((NUM_REQ-1-i) >= 32'(ptr)) begin
          win_hi   = PW'(NUM_REQ-1-i);
          found_hi = 1'b1;
        end
      end
    end
    win = found_hi ? win_hi : win_lo;

    win_oh = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == PW'(i)) begin
        win_oh[i] = 1'b1;
        sel_a     = bus.op_a[i*W +: W];
        sel_b     = bus.op_b[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      k            <= '0;
      cnt          <= '0;
      grant_q      <= '0;
      resp_valid_q <= '0;
      resp_sum_q   <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            grant_q <= win_oh;
            add_a_q <= sel_a;
            add_b_q <= sel_b;
            k       <= win;
            cnt     <= CW'(ADDER_LAT);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            resp_sum_q   <= bus.add_sum;
            resp_valid_q <= grant_q;
            state        <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          resp_valid_q <= '0;
          grant_q      <= '0;
          ptr          <= (k == PW'(NUM_REQ-1)) ? '0 : k + 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_sum   = resp_sum_q;
  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Round-robin arbiter and sequencer that time-shares one W-bit adder (sum width W+1) between NUM_REQ requesters.
- Grants one requester at a time and drives that requester's operands onto the shared adder.
- Waits out the adder latency, then returns the captured sum to the granted requester with a one-cycle valid pulse.
- Sits between requesting client blocks and the single shared adder instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
W, 4, operand width; sum width is W+1
ADDER_LAT, 1, shared adder latency in clocks from operand change to valid sum (0 = combinational)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
req  input  NUM_REQ  per-requester request level
op_a  input  NUM_REQ*W  requester i operand A in bits [i*W +: W]
op_b  input  NUM_REQ*W  requester i operand B in bits [i*W +: W]
add_a  output  W  operand A to shared adder, registered
add_b  output  W  operand B to shared adder, registered
add_sum  input  W+1  result from shared adder
grant  output  NUM_REQ  one-hot grant, registered
resp_valid  output  NUM_REQ  one-hot, one-cycle response strobe
resp_sum  output  W+1  captured sum, valid while resp_valid != 0
busy  output  1  high whenever state != IDLE

Behaviour:
- Only clock is clk. Reset is synchronous and active-low: rst_n sampled low at a rising edge of clk clears all state.
- Reset values: state=IDLE, grant=0, resp_valid=0, resp_sum=0, add_a=0, add_b=0, busy=0, rr pointer ptr=0, wait counter=0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If req != 0, pick winner k = first set bit searching ptr, ptr+1, ..., wrapping mod NUM_REQ.
  - At that edge: grant <= onehot(k); add_a <= op_a[k]; add_b <= op_b[k]; cnt <= ADDER_LAT; state <= WAIT.
  - If req == 0, stay in IDLE.
- WAIT:
  - Lasts exactly ADDER_LAT+1 cycles; cnt decrements each cycle.
  - On the edge where cnt == 0: resp_sum <= add_sum; resp_valid <= grant; state <= RESP.
  - add_a, add_b and grant are held stable throughout WAIT.
- RESP:
  - Lasts one cycle, with resp_valid high.
  - At the end of the cycle: resp_valid <= 0; grant <= 0; ptr <= (k+1) mod NUM_REQ; state <= IDLE.
- Timing, with grant edge E0:
  - resp_valid is high in the cycle after edge E0+ADDER_LAT+1.
  - The next grant can occur at E0+ADDER_LAT+3 at the earliest.
  - Throughput is one operation per ADDER_LAT+3 cycles.
- Handshake:
  - A requester holds req until it sees its resp_valid bit.
  - A req still high in IDLE after the response is treated as a new request. Round-robin order then favours the other requesters.
- Operands are sampled only at the grant edge; later changes to op_a/op_b have no effect on the in-flight operation.
- A granted requester dropping req mid-operation: the operation completes and the response still pulses.
- Requests arriving during WAIT/RESP are ignored until IDLE; there is no queueing beyond the req level.
- Arithmetic: the block performs none; resp_sum equals add_sum bit-exactly, including bit W (carry).
- Reset mid-operation: all state clears at that edge; no resp_valid for the aborted operation; ptr returns to 0.
- grant and resp_valid are always one-hot or zero.

Test Plan:
- Single request, NUM_REQ=4, ADDER_LAT=1 (registered adder model): req=0001, A0=5, B0=4 at cycle 0 -> grant=0001 after E0; add_a=5, add_b=4; resp_valid=0001 with resp_sum=9 in the cycle after E2; busy low again after E3.
- All four requesting simultaneously with distinct operands (i, i+1), each holding req until its own resp_valid -> serviced in order 0,1,2,3; resp_sum = 1,3,5,7; one grant every 4 cycles.
- Fairness: req0 held continuously, req2 pulsed on each return to IDLE -> grant order alternates 0,2,0,2; neither requester starves.
- Boundary: A=15, B=15 -> resp_sum=30 (5'b11110), carry bit set. A=0, B=0 -> resp_sum=0 and resp_valid still pulses.
- Reset mid-WAIT: rst_n low for 1 cycle during the second WAIT cycle -> next cycle all outputs 0, no resp_valid, ptr=0. A subsequent req=0100 is granted normally.
- ADDER_LAT=0 with a combinational adder model: A=7, B=8 -> WAIT lasts 1 cycle; resp_sum=15 with resp_valid in the cycle after E1.
